// File: rtl/gpu_pkg.sv
// Shared GPU encodings: core sequencer states, fetcher states and LSU states.
// Decoder, fetcher, LSUs and the core sequencer all import this package so the
// 3-bit core_state bus means the same thing everywhere.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // An LSU is still servicing its access while requesting or waiting.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/unit_done_tracker.sv
// Sticky per-thread completion mask for multi-cycle FMA/ACT operations.
// all_done also folds in this cycle's pulses so the sequencer can leave WAIT
// on the same edge that captures the final unit_done pulse.
module unit_done_tracker #(
  parameter int THREADS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               capture_en,
  input  logic [THREADS-1:0] unit_done,
  input  logic [THREADS-1:0] active,
  output logic               all_done
);

  logic [THREADS-1:0] mask;
  logic [THREADS-1:0] seen;

  // Accumulate completion pulses while the operation is in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (reset || clear) begin
      mask <= '0;
    end else if (capture_en) begin
      mask <= mask | unit_done;
    end
  end

  assign seen     = mask | (capture_en ? unit_done : '0);
  assign all_done = &(seen | ~active);

endmodule

// File: rtl/core_sequencer.sv
// Per-core control FSM: fetch, decode, request, wait, execute, update.
// Holds in WAIT until active threads finish memory accesses and FMA/ACT work,
// then commits slot 0 of next_pc, or parks in DONE on RET.
module core_sequencer
  import gpu_pkg::*;
#(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(THREADS):0]   thread_count,
  input  logic [2:0]                 fetcher_state,
  input  logic                       decoded_mem_read_enable,
  input  logic                       decoded_mem_write_enable,
  input  logic                       decoded_fma_enable,
  input  logic                       decoded_act_enable,
  input  logic                       decoded_ret,
  input  logic [2*THREADS-1:0]       lsu_state,
  input  logic [THREADS-1:0]         unit_done,
  input  logic [PC_BITS*THREADS-1:0] next_pc,
  output logic [2:0]                 core_state,
  output logic [PC_BITS-1:0]         current_pc,
  output logic                       unit_start,
  output logic                       done
);

  localparam int TC_W = $clog2(THREADS) + 1;

  core_state_e        state_q;
  core_state_e        state_d;
  logic [THREADS-1:0] active;
  logic [THREADS-1:0] mem_busy;
  logic               mem_op;
  logic               unit_op;
  logic               mem_ok;
  logic               unit_ok;
  logic               units_done;
  logic               mask_clear;
  logic               mask_capture;
  logic               unused_next_pc;

  // Only slot 0 of next_pc steers the core; other slots belong to the threads.
  assign unused_next_pc = ^next_pc[PC_BITS*THREADS-1:PC_BITS];

  genvar g;
  generate
    for (g = 0; g < THREADS; g++) begin : g_thread
      assign active[g]   = thread_count > TC_W'(g);
      assign mem_busy[g] = active[g] && lsu_busy(lsu_state[2*g +: 2]);
    end
  endgenerate

  assign mem_op  = decoded_mem_read_enable | decoded_mem_write_enable;
  assign unit_op = decoded_fma_enable | decoded_act_enable;
  assign mem_ok  = !mem_op || (mem_busy == '0);
  assign unit_ok = !unit_op || units_done;

  unit_done_tracker #(
    .THREADS (THREADS)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .clear      (mask_clear),
    .capture_en (mask_capture),
    .unit_done  (unit_done),
    .active     (active),
    .all_done   (units_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CORE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      CORE_IDLE:    if (start) state_d = CORE_FETCH;
      CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT:    if (mem_ok && unit_ok) state_d = CORE_EXECUTE;
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE:  state_d = decoded_ret ? CORE_DONE : CORE_FETCH;
      CORE_DONE:    state_d = CORE_DONE;
    endcase
  end

  // Outputs and tracker controls decoded from the registered state.
  always_comb begin
    unit_start   = 1'b0;
    done         = 1'b0;
    mask_clear   = 1'b0;
    mask_capture = 1'b0;
    case (state_q)
      CORE_DECODE:  mask_clear = 1'b1;
      CORE_REQUEST: begin
        unit_start   = unit_op;
        mask_capture = 1'b1;
      end
      CORE_WAIT:    mask_capture = 1'b1;
      CORE_DONE:    done = 1'b1;
      default:      ;
    endcase
  end

  // Commit the next PC at the end of each non-RET instruction; wraps freely.
  always_ff @(posedge clk) begin
    if (reset) begin
      current_pc <= '0;
    end else if (state_q == CORE_UPDATE && !decoded_ret) begin
      current_pc <= next_pc[PC_BITS-1:0];
    end
  end

  assign core_state = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_core_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  thread_count;
  logic [2:0]  fetcher_state;
  logic        mem_rd, mem_wr, fma, act, ret;
  logic [7:0]  lsu_state;
  logic [3:0]  unit_done;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        unit_start;
  logic        done;

  int total = 0;
  int bad   = 0;

  core_sequencer #(.THREADS(4), .PC_BITS(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_count             (thread_count),
    .fetcher_state            (fetcher_state),
    .decoded_mem_read_enable  (mem_rd),
    .decoded_mem_write_enable (mem_wr),
    .decoded_fma_enable       (fma),
    .decoded_act_enable       (act),
    .decoded_ret              (ret),
    .lsu_state                (lsu_state),
    .unit_done                (unit_done),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .unit_start               (unit_start),
    .done                     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_defaults();
    start         = 1'b0;
    thread_count  = 3'd4;
    fetcher_state = 3'b000;
    mem_rd = 1'b0; mem_wr = 1'b0; fma = 1'b0; act = 1'b0; ret = 1'b0;
    lsu_state     = 8'h00;
    unit_done     = 4'h0;
    next_pc       = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_defaults();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (core_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", core_state); end
    total++; if (current_pc !== 8'h00) begin bad++; $display("FAIL reset_pc got=%0h exp=0", current_pc); end
    total++; if (unit_start !== 1'b0) begin bad++; $display("FAIL reset_unit_start got=%b exp=0", unit_start); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (dut.u_tracker.mask !== 4'h0) begin bad++; $display("FAIL reset_mask got=%b exp=0000", dut.u_tracker.mask); end
  endtask

  // ADD then RET, four threads, fetcher needs two cycles the first time.
  task automatic test_straight_line();
    int exp_s [15] = '{0, 1, 1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6, 7};
    do_reset();
    next_pc = 32'h0000_0001;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      total++;
      if (core_state !== 3'(exp_s[c])) begin
        bad++; $display("FAIL straight_state c=%0d got=%0d exp=%0d", c, core_state, exp_s[c]);
      end
      case (c)
        0: start = 1'b1;
        1: begin start = 1'b0; fetcher_state = 3'b001; end
        2: fetcher_state = 3'b010;
        3: fetcher_state = 3'b000;
        4: begin
          total++; if (unit_start !== 1'b0) begin bad++; $display("FAIL straight_unit_start got=%b exp=0", unit_start); end
        end
        7: begin
          total++; if (current_pc !== 8'h00) begin bad++; $display("FAIL straight_pc0 got=%0h exp=0", current_pc); end
        end
        8: begin
          total++; if (current_pc !== 8'h01) begin bad++; $display("FAIL straight_pc1 got=%0h exp=1", current_pc); end
          fetcher_state = 3'b010;
        end
        9: begin fetcher_state = 3'b000; ret = 1'b1; next_pc = 32'h0000_0055; end
        14: begin
          total++; if (done !== 1'b1) begin bad++; $display("FAIL straight_done got=%b exp=1", done); end
          total++; if (current_pc !== 8'h01) begin bad++; $display("FAIL straight_ret_pc got=%0h exp=1", current_pc); end
        end
        default: ;
      endcase
    end
  endtask

  // LDR stalled by thread 2, then STR with an inactive busy thread 3.
  task automatic test_memory_stall();
    int exp_s [17] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 4, 5, 6, 1, 2, 3, 4, 5};
    do_reset();
    next_pc = 32'h0000_0001;
    fetcher_state = 3'b010;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      total++;
      if (core_state !== 3'(exp_s[c])) begin
        bad++; $display("FAIL mem_state c=%0d got=%0d exp=%0d", c, core_state, exp_s[c]);
      end
      case (c)
        0: start = 1'b1;
        1: start = 1'b0;
        2: mem_rd = 1'b1;
        3: lsu_state = 8'b01_01_01_01;
        4, 5, 6, 7, 8: lsu_state = 8'b11_10_11_11;
        9: lsu_state = 8'hFF;
        10: lsu_state = 8'h00;
        13: begin mem_rd = 1'b0; mem_wr = 1'b1; thread_count = 3'd2; lsu_state = 8'b10_00_00_00; end
        default: ;
      endcase
    end
  endtask

  // FMA on three threads with staggered completion; thread 3 never reports.
  task automatic test_fma_gating();
    int exp_s [10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6};
    do_reset();
    fetcher_state = 3'b010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (core_state !== 3'(exp_s[c])) begin
        bad++; $display("FAIL fma_state c=%0d got=%0d exp=%0d", c, core_state, exp_s[c]);
      end
      total++;
      if (unit_start !== (c == 3)) begin
        bad++; $display("FAIL fma_unit_start c=%0d got=%b exp=%b", c, unit_start, (c == 3));
      end
      unit_done = 4'h0;
      case (c)
        0: start = 1'b1;
        1: start = 1'b0;
        2: begin fma = 1'b1; thread_count = 3'd3; end
        4: unit_done = 4'b0001;
        6: unit_done = 4'b0100;
        7: unit_done = 4'b0010;
        default: ;
      endcase
    end
  endtask

  // ACT with no active threads; PC follows slot 0 and wraps 0xFF -> 0x00.
  task automatic test_branch();
    int exp_v;
    do_reset();
    fetcher_state = 3'b010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      exp_v = (c == 0) ? 0 : ((c - 1) % 6) + 1;
      total++;
      if (core_state !== 3'(exp_v)) begin
        bad++; $display("FAIL branch_state c=%0d got=%0d exp=%0d", c, core_state, exp_v);
      end
      if (c % 6 == 3) begin
        total++;
        if (unit_start !== 1'b1) begin bad++; $display("FAIL branch_unit_start c=%0d got=%b exp=1", c, unit_start); end
      end
      case (c)
        0: start = 1'b1;
        1: start = 1'b0;
        2: begin act = 1'b1; thread_count = 3'd0; next_pc = 32'h0000_051F; end
        7: begin
          total++; if (current_pc !== 8'h1F) begin bad++; $display("FAIL branch_pc got=%0h exp=1f", current_pc); end
          next_pc = 32'h0000_05FF;
        end
        13: begin
          total++; if (current_pc !== 8'hFF) begin bad++; $display("FAIL branch_pc_ff got=%0h exp=ff", current_pc); end
          next_pc = 32'h0000_0500;
        end
        19: begin
          total++; if (current_pc !== 8'h00) begin bad++; $display("FAIL branch_pc_wrap got=%0h exp=0", current_pc); end
        end
        default: ;
      endcase
    end
  endtask

  // Reset during an FMA stall, stray pulses in IDLE, then a clean rerun.
  task automatic test_reset_mid_wait();
    int exp_s [20] = '{0, 1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 4, 0, 0, 1, 2, 3, 4, 4, 5};
    do_reset();
    fetcher_state = 3'b010;
    next_pc = 32'h0000_002A;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (core_state !== 3'(exp_s[c])) begin
        bad++; $display("FAIL rst_wait_state c=%0d got=%0d exp=%0d", c, core_state, exp_s[c]);
      end
      unit_done = 4'h0;
      case (c)
        0: start = 1'b1;
        1: start = 1'b0;
        7: begin
          total++; if (current_pc !== 8'h2A) begin bad++; $display("FAIL rst_wait_pc_pre got=%0h exp=2a", current_pc); end
        end
        8: fma = 1'b1;
        10: unit_done = 4'b0001;
        11: reset = 1'b1;
        12: begin
          total++; if (current_pc !== 8'h00) begin bad++; $display("FAIL rst_wait_pc got=%0h exp=0", current_pc); end
          total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_wait_done got=%b exp=0", done); end
          reset = 1'b0;
          unit_done = 4'hF;
        end
        13: begin
          total++; if (dut.u_tracker.mask !== 4'h0) begin bad++; $display("FAIL rst_wait_mask got=%b exp=0000", dut.u_tracker.mask); end
          start = 1'b1;
        end
        14: begin
          start = 1'b0;
          total++; if (current_pc !== 8'h00) begin bad++; $display("FAIL rst_wait_rerun_pc got=%0h exp=0", current_pc); end
        end
        18: unit_done = 4'hF;
        default: ;
      endcase
    end
  endtask

  // start held through DONE; start together with reset stays in IDLE.
  task automatic test_start_done();
    int exp_s [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 0, 0, 1};
    do_reset();
    fetcher_state = 3'b010;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      total++;
      if (core_state !== 3'(exp_s[c])) begin
        bad++; $display("FAIL sd_state c=%0d got=%0d exp=%0d", c, core_state, exp_s[c]);
      end
      if (c >= 7) begin
        total++;
        if (done !== (c <= 11)) begin bad++; $display("FAIL sd_done c=%0d got=%b exp=%b", c, done, (c <= 11)); end
      end
      case (c)
        0: begin start = 1'b1; ret = 1'b1; end
        11: reset = 1'b1;
        13: reset = 1'b0;
        default: ;
      endcase
    end
  endtask

  initial begin
    reset = 1'b1;
    set_defaults();
    test_reset();
    test_straight_line();
    test_memory_stall();
    test_fma_gating();
    test_branch();
    test_reset_mid_wait();
    test_start_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Per-core control FSM that drives the 3-bit `core_state` consumed by the instruction decoder, fetcher, LSUs, FMA and ACT units. It sequences each instruction through fetch, decode, operand/memory request, wait and execute, then commits the PC. It waits for multi-cycle memory and Q1.15 FMA/ACT operations on all active threads before committing. It sits in each core beside the decoder, one instance per core.

## Interface
Parameters:
- `THREADS`, 4: threads per core.
- `PC_BITS`, 8: program counter width.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level; begin executing block at PC 0.
- `thread_count`  in  $clog2(THREADS)+1  active threads; threads `0..thread_count-1` are active.
- `fetcher_state`  in  3  000 IDLE, 001 FETCHING, 010 FETCHED.
- `decoded_mem_read_enable`, `decoded_mem_write_enable`, `decoded_fma_enable`, `decoded_act_enable`, `decoded_ret`  in  1 each  decoder outputs; combinational, stable while the instruction is held.
- `lsu_state`  in  2*THREADS  per-thread; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
- `unit_done`  in  THREADS  per-thread single-cycle pulse from the FMA/ACT unit.
- `next_pc`  in  PC_BITS*THREADS  per-thread next PC; slot 0 is authoritative.
- `core_state`  out  3  current state.
- `current_pc`  out  PC_BITS  PC of the instruction being processed.
- `unit_start`  out  1  one-cycle pulse launching FMA/ACT on all active threads.
- `done`  out  1  block finished; held until reset.

## Operation
- States: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- IDLE → FETCH when `start`=1. `current_pc` is 0.
- FETCH → DECODE when `fetcher_state`==FETCHED. Otherwise hold.
- DECODE → REQUEST after exactly 1 cycle. This cycle lets the combinational decode settle.
- REQUEST → WAIT after exactly 1 cycle.
  - `unit_start`=1 during REQUEST iff `decoded_fma_enable | decoded_act_enable`.
  - `done_mask` is cleared on entry to REQUEST.
- `done_mask[i]` is set by `unit_done[i]`. Capture is enabled in REQUEST and WAIT, so a pulse in the first WAIT cycle is not lost.
- WAIT → EXECUTE when both conditions hold:
  - **Memory:** if the instruction is a memory op, no active thread has `lsu_state` ∈ {01, 10}.
  - **Unit:** if the instruction is FMA/ACT, `done_mask` is set for every active thread.
  - Inactive threads are ignored.
  - Non-memory, non-unit ops leave WAIT after 1 cycle.
- EXECUTE → UPDATE after exactly 1 cycle.
- UPDATE, after 1 cycle:
  - If `decoded_ret`=1: go to DONE and set `done`=1. PC is unchanged.
  - Otherwise: `current_pc` ← `next_pc[PC_BITS-1:0]`, go to FETCH.
- DONE: absorbing; exits only on reset. `start` is ignored.
- `thread_count`=0: memory and unit conditions are trivially true. Instructions still step and RET still terminates.
- PC wrap-around: `next_pc` is taken verbatim. The PC wraps modulo 2^PC_BITS, with no detection.
- Stray `unit_done` pulses outside REQUEST/WAIT are ignored.

## Timing
- Reset values: `core_state`=000, `current_pc`=0, `unit_start`=0, `done`=0, `done_mask`=0.
- Reset mid-operation returns to IDLE on the next edge, regardless of state.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs, except `unit_start`, which is gated by the registered state and decoder levels.
- Minimum instruction latency is 6 cycles: FETCHED seen in FETCH, then DECODE, REQUEST, WAIT(1), EXECUTE, UPDATE.
- `start` is sampled only in IDLE. `start` and `reset` asserted together: reset wins.
- `unit_done` and WAIT exit on the same edge: a pulse completing the mask in cycle N causes the EXECUTE transition at edge N+1.

## Structure
- Shared package `gpu_pkg` holds:
  - the `core_state` encoding constants (8 states);
  - the fetcher state encodings;
  - the LSU state encodings.
- Decoder, fetcher and LSUs import the same package.
- Natural sub-module: `unit_done_tracker`, the THREADS-wide sticky mask with clear, capture enable and active-thread compare.

## Test plan
- **Straight-line:** `start`, fetcher returns FETCHED after 2 cycles, ADD, then RET; `thread_count`=4.
  - Visits 001→010→011→100→101→110→001; `current_pc` 0→1.
  - Second instruction's UPDATE → 111, `done`=1.
- **Memory stall:** LDR, with thread 2 `lsu_state`=10 for 5 cycles after REQUEST.
  - WAIT held exactly while thread 2 is busy; EXECUTE the cycle after it reaches 11.
- **FMA gating:** FMA with `thread_count`=3; `unit_done` pulses thread 0 at cycle+1, thread 2 at +3, thread 1 at +4; thread 3 never pulses.
  - `unit_start` is a single 1-cycle pulse in REQUEST.
  - EXECUTE follows the +4 pulse.
- **Branch:** `next_pc` slot 0 = 0x1F, slot 1 = 0x05.
  - `current_pc`=0x1F after UPDATE.
  - With `next_pc`=0xFF, then 0x00: wraps without error.
- **Reset mid-WAIT:** during an FMA stall, assert `reset` 1 cycle.
  - Next cycle `core_state`=000, `current_pc`=0, `done`=0.
  - Late `unit_done` pulses are ignored and the next run starts clean.
- **Start/DONE:** `start` held high through DONE → remains 111.
  - `start` with `reset` high → stays IDLE.
